// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio frame path: default sample width,
// frame FSM state and the two's-complement magnitude used by peak tracking.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

  // |s| for a two's-complement sample; the most negative code saturates to max positive.
  function automatic logic [AUDIO_DATA_W-2:0] abs_sat(input logic [AUDIO_DATA_W-1:0] s);
    logic [AUDIO_DATA_W-1:0] mag;
    mag = s[AUDIO_DATA_W-1] ? (~s + 1'b1) : s;
    if (mag[AUDIO_DATA_W-1]) return {(AUDIO_DATA_W-1){1'b1}};
    return mag[AUDIO_DATA_W-2:0];
  endfunction

endpackage

// File: rtl/audio_skid_buf.sv
// Two-entry valid/ready buffer; registered output, one cycle write-to-read latency.
// wr_ready depends only on occupancy, so there is no combinational path from rd_ready upstream.
module audio_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         wr_ready,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign wr_ready = (occ != 2'd2);
  assign push     = wr_valid && wr_ready;
  assign rd_valid = (occ != 2'd0);
  assign pop      = rd_valid && rd_ready;
  // Writes always land in the other slot while the head is occupied, so the head holds stable.
  assign rd_data  = ent[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_reader.sv
// Pops FWFT FIFO samples into fixed-length sop/eop-tagged frames; optional peak output under AUDIO_FRAME_PEAK_EN.
// One cycle pop-to-output latency; m_ready stalls are absorbed by a 2-entry skid buffer, frames never truncate.
module audio_frame_reader
  import audio_pkg::*;
#(
  parameter int DATA_W    = AUDIO_DATA_W,
  parameter int FRAME_LEN = 256,
  parameter int IDX_W     = 11,
  parameter int FCNT_W    = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic [IDX_W-1:0]  m_idx,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic              busy
`ifdef AUDIO_FRAME_PEAK_EN
  ,
  output logic [DATA_W-2:0] peak_val,
  output logic              peak_vld
`endif
);

  localparam int               PW   = DATA_W + 2 + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  frame_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       occ;
  logic             buf_ready;
  logic             pop;
  logic             last;
  logic [PW-1:0]    buf_out;

  assign pop        = fifo_rd_vld && (state == RUN) && buf_ready;
  assign fifo_rd_en = pop;
  assign last       = (idx == LAST);
  assign busy       = (state == RUN) || (occ != 2'd0);

  audio_skid_buf #(.W(PW)) u_skid (
    .clk      (rd_clk),
    .rst      (rd_rst),
    .wr_valid (pop),
    .wr_data  ({fifo_rd_data, (idx == '0), last, idx}),
    .wr_ready (buf_ready),
    .rd_valid (m_valid),
    .rd_ready (m_ready),
    .rd_data  (buf_out),
    .occ      (occ)
  );

  assign {m_data, m_sop, m_eop, m_idx} = buf_out;

  // enable is only looked at in IDLE and on the last pop of a frame.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          if (pop) begin
            if (last) begin
              idx       <= '0;
              frame_cnt <= frame_cnt + 1'b1;
              if (!enable) state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) underrun <= 1'b0;
    else if ((state == RUN) && (idx != '0) && !fifo_rd_vld) underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

`ifdef AUDIO_FRAME_PEAK_EN
  logic [DATA_W-2:0] run_max;
  logic [DATA_W-2:0] cur_abs;
  logic [DATA_W-2:0] frame_max;

  assign cur_abs   = abs_sat(fifo_rd_data);
  // The first sample of a frame restarts the running maximum.
  assign frame_max = ((idx == '0) || (cur_abs > run_max)) ? cur_abs : run_max;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      run_max  <= '0;
      peak_val <= '0;
      peak_vld <= 1'b0;
    end else begin
      peak_vld <= 1'b0;
      if (pop) begin
        run_max <= frame_max;
        if (last) begin
          peak_val <= frame_max;
          peak_vld <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/audio_frame_reader.md
Name: audio_frame_reader

Overview:
- Read-side consumer of the 2048x16 prefetch (first-word-fall-through) sample FIFO.
- Pops 16-bit PCM samples and groups them into fixed-length frames.
- Presents the frames on a valid/ready stream with start-of-frame (sop), end-of-frame (eop) and sample index, for the downstream processing chain.
- Frames are atomic: once a frame starts it is always completed. Starvation mid-frame is flagged.

Parameters:
- DATA_W, 16, sample width; matches the FIFO read width.
- FRAME_LEN, 256, samples per frame; legal range 2..2048.
- IDX_W, 11, width of m_idx; must satisfy 2^IDX_W >= FRAME_LEN.
- FCNT_W, 16, width of the frame counter.

Ports:
- rd_clk, in, 1, single clock (the FIFO read clock).
- rd_rst, in, 1, asynchronous, active-high reset.
- enable, in, 1, level; allows new frames to start.
- fifo_rd_en, out, 1, pop strobe to the FIFO.
- fifo_rd_vld, in, 1, FIFO head word is valid.
- fifo_rd_data, in, DATA_W, FIFO head word.
- m_valid, out, 1, output sample valid.
- m_ready, in, 1, downstream accept.
- m_data, out, DATA_W, output sample.
- m_sop, out, 1, first sample of a frame.
- m_eop, out, 1, last sample of a frame.
- m_idx, out, IDX_W, sample index within the frame.
- frame_cnt, out, FCNT_W, count of frames fully popped from the FIFO; wraps.
- underrun, out, 1, sticky flag: FIFO ran empty mid-frame.
- underrun_clr, in, 1, synchronous clear for underrun.
- busy, out, 1, a frame is in progress or the output buffer is non-empty.

Behaviour:
- Reset values: all outputs 0, both buffer entries empty, state IDLE, internal sample index 0.
- Pop rule:
  - fifo_rd_en = fifo_rd_vld && state==RUN && buffer occupancy < 2.
  - fifo_rd_en never asserts while fifo_rd_vld is low.
  - A pop consumes fifo_rd_data in that same cycle.
- Latency: a sample popped in cycle N is presented on m_valid/m_data in cycle N+1 at the earliest.
- Output handshake:
  - A transfer occurs when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_sop, m_eop and m_idx hold stable.
- Throughput: 1 sample/clk when fifo_rd_vld=1 and m_ready=1 continuously.
- Buffering: 2-entry skid buffer, so fifo_rd_en has no combinational path from m_ready.
- State machine:
  - IDLE: when enable=1, go to RUN and set index to 0.
  - RUN: pop samples; each pop tags sop=(idx==0), eop=(idx==FRAME_LEN-1), m_idx=idx.
    - On a pop with idx==FRAME_LEN-1: idx goes to 0 and frame_cnt increments.
    - At that same point: if enable=0, go to IDLE; otherwise stay in RUN.
- enable is sampled only at frame boundaries. Deasserting enable mid-frame never truncates the frame.
- Starvation:
  - In RUN with idx!=0 and fifo_rd_vld=0, set underrun=1 and wait. No sample is dropped or duplicated.
  - With idx==0 and fifo_rd_vld=0 (between frames), underrun is not set.
- underrun_clr:
  - Clears underrun.
  - If a set condition occurs in the same cycle, set wins.
- busy = (state==RUN) || (buffer occupancy != 0).
- frame_cnt wraps from 2^FCNT_W-1 to 0.
- Asynchronous reset mid-frame:
  - Immediately discards buffered samples and the partial frame; all outputs return to reset values.
  - Samples left in the FIFO are the upstream owner's responsibility.

Optional Feature:
- Macro: AUDIO_FRAME_PEAK_EN.
- When defined, adds two outputs: peak_val (DATA_W-1 bits, unsigned) and peak_vld (1 bit, a one-cycle pulse).
  - Tracks the maximum |sample| over each frame at pop time, treating samples as two's complement.
  - |-32768| saturates to 32767.
  - On the eop pop, peak_val is updated to the frame maximum and peak_vld pulses for one cycle.
  - The running maximum then resets to the next frame's first sample.
  - Both outputs reset to 0.
- When not defined: the ports are absent and there is no peak logic.

Decomposition:
- Shared package audio_pkg holds:
  - the DATA_W default,
  - the frame-state typedef (IDLE, RUN),
  - the abs-saturate function used by the peak logic.
- Sub-module audio_skid_buf: a 2-entry valid/ready buffer, DATA_W+2+IDX_W bits wide, exposing an occupancy output. It is reusable by other stream stages.

Test Plan:
- FRAME_LEN=4, FIFO preloaded with 8 samples 1..8, enable=1, m_ready=1:
  - output is 1..8 on consecutive cycles;
  - sop on 1 and 5, eop on 4 and 8, m_idx 0,1,2,3,0,1,2,3;
  - frame_cnt=2; underrun=0.
- Same setup, enable dropped after sample 2 is output → samples 3 and 4 are still output, then state returns to IDLE; sample 5 stays in the FIFO; frame_cnt=1.
- FIFO holds only 2 samples mid-frame, a 3rd arrives 5 cycles later:
  - underrun=1 during the wait, no duplicate output;
  - underrun_clr pulse → 0.
- m_ready toggled 1,0,0,1 during streaming:
  - m_data held stable while m_ready=0;
  - at most 2 samples are popped ahead;
  - no sample is lost.
- rd_rst asserted mid-frame with 2 samples buffered:
  - m_valid=0 and busy=0 immediately;
  - after release with enable=1, the next pop is tagged sop and m_idx=0.
- With AUDIO_FRAME_PEAK_EN defined, frame {100, -32768, 5, -7} → peak_vld pulses with peak_val=32767; next frame {3, -9, 2, 1} → peak_val=9.
